// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button debounce and short/long press classification,
// CLEAR/RUN/PAUSE mode FSM driving the time counter, and the lap register file.
module stopwatch_ctrl #(
  parameter int DEB_CYC   = 500000,
  parameter int SHORT_CYC = 1000000,
  parameter int LONG_CYC  = 50000000,
  parameter int LAPS      = 9
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        buttonA,
  input  logic        buttonB,
  input  logic [15:0] time_bcd,
  input  logic        time_max,
  output logic        cnt_clr,
  output logic        cnt_en,
  output logic [15:0] lap_rdata,
  output logic        lap_valid,
  output logic [2:0]  state,
  output logic [8:0]  wrnum,
  output logic [8:0]  rdnum
);

  localparam logic [31:0] DEB_LAST = 32'(DEB_CYC - 1);
  localparam logic [31:0] SHORT_TH = 32'(SHORT_CYC);
  localparam logic [31:0] LONG_TH  = 32'(LONG_CYC);
  localparam logic [31:0] LONG_PRE = 32'(LONG_CYC - 1);
  localparam logic [3:0]  PTR_LAST = 4'(LAPS - 1);
  localparam logic [4:0]  CNT_MAX  = 5'(LAPS);

  typedef enum logic [1:0] {S_CLEAR = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2} mode_e;

  function automatic logic [2:0] mode_onehot(input mode_e m);
    case (m)
      S_CLEAR: return 3'b100;
      S_RUN:   return 3'b010;
      S_PAUSE: return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [8:0] ptr_onehot(input logic [3:0] ptr);
    return (ptr < 4'd9) ? (9'b1_0000_0000 >> ptr) : 9'd0;
  endfunction

  // Index 0 is button A, index 1 is button B.
  logic [1:0]  raw_s, tick_s;
  logic [31:0] deb_cnt_r [2];
  logic [31:0] hold_r [2];
  logic [1:0]  level_r, armed_r, short_r, long_r;
  logic        a_long_s, a_short_s, b_short_s, b_long_s;

  assign raw_s  = {buttonB, buttonA};
  assign tick_s = {deb_cnt_r[1] == DEB_LAST, deb_cnt_r[0] == DEB_LAST};

  // Debounce sampling, hold timing and press classification for both buttons.
  // A press is only timed once the button has been seen released after reset,
  // so a press spanning reset can never produce an event.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        deb_cnt_r[i] <= 32'd0;
        hold_r[i]    <= 32'd0;
      end
      level_r <= 2'b11;
      armed_r <= 2'b00;
      short_r <= 2'b00;
      long_r  <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        deb_cnt_r[i] <= tick_s[i] ? 32'd0 : deb_cnt_r[i] + 32'd1;
        if (tick_s[i]) begin
          level_r[i] <= raw_s[i];
          if (raw_s[i]) armed_r[i] <= 1'b1;
        end
        if (!level_r[i] && armed_r[i]) begin
          if (hold_r[i] != LONG_TH) hold_r[i] <= hold_r[i] + 32'd1;
        end else begin
          hold_r[i] <= 32'd0;
        end
        long_r[i]  <= !level_r[i] && armed_r[i] && (hold_r[i] == LONG_PRE)
                      && !(tick_s[i] && raw_s[i]);
        short_r[i] <= tick_s[i] && raw_s[i] && !level_r[i]
                      && (hold_r[i] >= SHORT_TH) && (hold_r[i] < LONG_TH);
      end
    end
  end

  // A events win over B events arriving in the same cycle.
  assign a_long_s  = long_r[0];
  assign a_short_s = short_r[0] && !long_r[0];
  assign b_short_s = short_r[1] && !long_r[0] && !short_r[0];
  assign b_long_s  = long_r[1]  && !long_r[0] && !short_r[0];

  mode_e       mode_r, mode_s;
  logic [3:0]  wptr_r, wptr_s, rptr_r, rptr_s, rd_sel_s;
  logic [4:0]  lap_count_r, lap_count_s;
  logic        wr_en_s;
  logic [15:0] lap_mem_r [LAPS];
  logic        run_r, cnt_clr_r, lap_valid_r;
  logic [15:0] lap_rdata_r;
  logic [2:0]  state_r;
  logic [8:0]  wrnum_r, rdnum_r;

  // Next mode, pointer and lap-count computation from the classified events.
  always_comb begin
    mode_s      = mode_r;
    wptr_s      = wptr_r;
    rptr_s      = rptr_r;
    lap_count_s = lap_count_r;
    wr_en_s     = 1'b0;
    if (a_long_s) begin
      mode_s = S_CLEAR;
    end else begin
      case (mode_r)
        S_CLEAR: begin
          wptr_s      = 4'd0;
          rptr_s      = 4'd0;
          lap_count_s = 5'd0;
          if (a_short_s) mode_s = S_RUN;
          else           mode_s = S_CLEAR;
        end
        S_RUN: begin
          if (a_short_s || time_max) begin
            mode_s = S_PAUSE;
            rptr_s = 4'd0;
          end else begin
            mode_s = S_RUN;
          end
          if (b_short_s) begin
            wr_en_s     = 1'b1;
            wptr_s      = (wptr_r == PTR_LAST) ? 4'd0 : wptr_r + 4'd1;
            lap_count_s = (lap_count_r == CNT_MAX) ? CNT_MAX : lap_count_r + 5'd1;
          end else begin
            wr_en_s = 1'b0;
          end
        end
        S_PAUSE: begin
          if (a_short_s) mode_s = S_RUN;
          else           mode_s = S_PAUSE;
          if (b_long_s) begin
            wptr_s      = 4'd0;
            rptr_s      = 4'd0;
            lap_count_s = 5'd0;
          end else if (b_short_s && (lap_count_r != 5'd0)) begin
            rptr_s = ({1'b0, rptr_r} == lap_count_r - 5'd1) ? 4'd0 : rptr_r + 4'd1;
          end else begin
            rptr_s = rptr_r;
          end
        end
        default: mode_s = S_CLEAR;
      endcase
    end
  end

  // RUN shows the newest lap; PAUSE browses with the read pointer.
  assign rd_sel_s = (mode_r == S_RUN) ? ((wptr_r == 4'd0) ? PTR_LAST : wptr_r - 4'd1)
                                      : rptr_r;

  // Mode FSM, lap storage and registered outputs.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      mode_r      <= S_CLEAR;
      wptr_r      <= 4'd0;
      rptr_r      <= 4'd0;
      lap_count_r <= 5'd0;
      for (int i = 0; i < LAPS; i++) lap_mem_r[i] <= 16'h0000;
      cnt_clr_r   <= 1'b1;
      run_r       <= 1'b0;
      state_r     <= 3'b100;
      wrnum_r     <= 9'b1_0000_0000;
      rdnum_r     <= 9'b1_0000_0000;
      lap_valid_r <= 1'b0;
      lap_rdata_r <= 16'h0000;
    end else begin
      mode_r      <= mode_s;
      wptr_r      <= wptr_s;
      rptr_r      <= rptr_s;
      lap_count_r <= lap_count_s;
      if (wr_en_s) lap_mem_r[wptr_r] <= time_bcd;
      cnt_clr_r   <= (mode_s == S_CLEAR);
      run_r       <= (mode_s == S_RUN);
      state_r     <= mode_onehot(mode_s);
      wrnum_r     <= ptr_onehot(wptr_s);
      rdnum_r     <= ptr_onehot(rptr_s);
      lap_valid_r <= (lap_count_r != 5'd0) && (mode_r != S_CLEAR);
      lap_rdata_r <= ((lap_count_r != 5'd0) && (mode_r != S_CLEAR)) ? lap_mem_r[rd_sel_s]
                                                                     : 16'h0000;
    end
  end

  // Counting stops in the very cycle the counter reports 60.00 s.
  assign cnt_en    = run_r && !time_max;
  assign cnt_clr   = cnt_clr_r;
  assign state     = state_r;
  assign wrnum     = wrnum_r;
  assign rdnum     = rdnum_r;
  assign lap_valid = lap_valid_r;
  assign lap_rdata = lap_rdata_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with shortened timing parameters and a
// transaction-level reference model of modes and laps.
module tb_stopwatch_ctrl;

  localparam int DEB    = 4;
  localparam int SHORT  = 40;
  localparam int LONG   = 200;
  localparam int LAPS   = 9;
  localparam int SETTLE = 24;
  localparam int M_CLEAR = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic        clock = 1'b0;
  logic        rst;
  logic        buttonA, buttonB;
  logic [15:0] time_bcd;
  logic        time_max;
  logic        cnt_clr, cnt_en, lap_valid;
  logic [15:0] lap_rdata;
  logic [2:0]  state;
  logic [8:0]  wrnum, rdnum;
  logic [39:0] obs;

  stopwatch_ctrl #(.DEB_CYC(DEB), .SHORT_CYC(SHORT), .LONG_CYC(LONG), .LAPS(LAPS)) dut (
    .clock(clock), .rst(rst), .buttonA(buttonA), .buttonB(buttonB),
    .time_bcd(time_bcd), .time_max(time_max), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
    .lap_rdata(lap_rdata), .lap_valid(lap_valid), .state(state),
    .wrnum(wrnum), .rdnum(rdnum)
  );

  always #5 clock = ~clock;

  assign obs = {cnt_clr, cnt_en, lap_valid, lap_rdata, state, wrnum, rdnum};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode, total writes since the last clear, read index.
  int          m_mode, m_writes, m_rptr;
  logic [15:0] m_mem [LAPS];

  task automatic m_reset();
    m_mode = M_CLEAR; m_writes = 0; m_rptr = 0;
  endtask

  task automatic m_a_short();
    case (m_mode)
      M_CLEAR: m_mode = M_RUN;
      M_RUN:   begin m_mode = M_PAUSE; m_rptr = 0; end
      default: m_mode = M_RUN;
    endcase
  endtask

  task automatic m_b_short();
    int c;
    c = (m_writes > LAPS) ? LAPS : m_writes;
    if (m_mode == M_RUN) begin
      m_mem[m_writes % LAPS] = time_bcd;
      m_writes++;
    end else if (m_mode == M_PAUSE && c != 0) begin
      m_rptr = (m_rptr + 1) % c;
    end
  endtask

  task automatic m_b_long();
    if (m_mode == M_PAUSE) begin m_writes = 0; m_rptr = 0; end
  endtask

  task automatic m_a_long();
    m_mode = M_CLEAR; m_writes = 0; m_rptr = 0;
  endtask

  task automatic m_tmax();
    if (m_mode == M_RUN) begin m_mode = M_PAUSE; m_rptr = 0; end
  endtask

  function automatic logic [39:0] model_vec();
    int w, c;
    logic v;
    logic [15:0] d;
    logic [2:0] st;
    logic [8:0] wn, rn;
    w  = m_writes % LAPS;
    c  = (m_writes > LAPS) ? LAPS : m_writes;
    v  = (c != 0) && (m_mode != M_CLEAR);
    d  = 16'h0000;
    if (v) d = (m_mode == M_RUN) ? m_mem[(w + LAPS - 1) % LAPS] : m_mem[m_rptr];
    st = (m_mode == M_CLEAR) ? 3'b100 : (m_mode == M_RUN) ? 3'b010 : 3'b001;
    wn = 9'h100 >> w;
    rn = 9'h100 >> m_rptr;
    return {m_mode == M_CLEAR, m_mode == M_RUN, v, d, st, wn, rn};
  endfunction

  function automatic logic [15:0] rand_bcd();
    return {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_btn(input bit which, input logic v);
    if (which) buttonB = v;
    else       buttonA = v;
  endtask

  // Press with contact bounce on both edges, then wait for the release to settle.
  task automatic press(input bit which, input int hold);
    drive_btn(which, 1'b0); cyc(1);
    drive_btn(which, 1'b1); cyc(1);
    drive_btn(which, 1'b0); cyc(hold);
    drive_btn(which, 1'b1); cyc(1);
    drive_btn(which, 1'b0); cyc(1);
    drive_btn(which, 1'b1); cyc(SETTLE);
  endtask

  task automatic do_reset();
    rst = 1'b0; buttonA = 1'b1; buttonB = 1'b1; time_max = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(2 * DEB + 2);
    m_reset();
  endtask

  task automatic test_reset();
    logic [39:0] exp_rst;
    exp_rst = {1'b1, 1'b0, 1'b0, 16'h0000, 3'b100, 9'h100, 9'h100};
    rst = 1'b0; buttonA = 1'b1; buttonB = 1'b1; time_max = 1'b0; time_bcd = 16'h0000;
    cyc(3);
    n_checks++;
    if (obs !== exp_rst) $display("FAIL reset_values: got %h expected %h", obs, exp_rst);
    else n_pass++;
    rst = 1'b1;
    cyc(2 * DEB + 2);
    m_reset();
  endtask

  task automatic test_start();
    for (int k = 0; k < DEB - 1; k++) begin buttonA = k[0]; cyc(1); end
    n_checks++;
    if (obs !== model_vec()) $display("FAIL bounce_no_event: got %h expected %h", obs, model_vec());
    else n_pass++;
    buttonA = 1'b0; cyc(SHORT + SHORT / 5);
    buttonA = 1'b1; cyc(SETTLE);
    m_a_short();
    n_checks++;
    if ({cnt_en, cnt_clr, state} !== {1'b1, 1'b0, 3'b010})
      $display("FAIL start_outputs: got %b expected %b", {cnt_en, cnt_clr, state}, 5'b10010);
    else n_pass++;
    n_checks++;
    if (obs !== model_vec()) $display("FAIL start_run: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_lap_write();
    bit seen;
    time_bcd = 16'h1234;
    buttonB = 1'b0; cyc(60);
    buttonB = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc(1);
      if (wrnum === 9'b010000000) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL lap_wr_seen: got wrnum %b expected 010000000", wrnum);
    else n_pass++;
    n_checks++;
    if (lap_valid !== 1'b0) $display("FAIL lap_valid_lag: got %b expected 0", lap_valid);
    else n_pass++;
    cyc(1);
    n_checks++;
    if ({lap_valid, lap_rdata} !== {1'b1, 16'h1234})
      $display("FAIL lap_rdata_next: got %b/%h expected 1/1234", lap_valid, lap_rdata);
    else n_pass++;
    m_b_short();
    cyc(SETTLE);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL lap_write: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [15:0] last_v;
    do_reset();
    press(1'b0, 70); m_a_short();
    last_v = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      time_bcd = {4'(i), 4'd5, 4'd0, 4'(9 - i)};
      last_v   = time_bcd;
      press(1'b1, 80); m_b_short();
    end
    n_checks++;
    if ({wrnum, lap_rdata} !== {9'b010000000, last_v})
      $display("FAIL wrap_ptr: got %b/%h expected 010000000/%h", wrnum, lap_rdata, last_v);
    else n_pass++;
    n_checks++;
    if (obs !== model_vec()) $display("FAIL wrap_state: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_pause_read();
    int exp_r [4] = '{1, 2, 0, 1};
    do_reset();
    press(1'b0, 70); m_a_short();
    for (int i = 0; i < 3; i++) begin
      time_bcd = {4'd1, 4'(i), 4'd7, 4'(i + 2)};
      press(1'b1, 90); m_b_short();
    end
    press(1'b0, 90); m_a_short();
    n_checks++;
    if ({rdnum, cnt_en} !== {9'h100, 1'b0})
      $display("FAIL pause_entry: got %b/%b expected 100000000/0", rdnum, cnt_en);
    else n_pass++;
    for (int j = 0; j < 4; j++) begin
      press(1'b1, 70); m_b_short();
      n_checks++;
      if ({rdnum, cnt_en} !== {9'(9'h100 >> exp_r[j]), 1'b0})
        $display("FAIL pause_rdnum: step %0d got %b expected rptr %0d", j, rdnum, exp_r[j]);
      else n_pass++;
      n_checks++;
      if (obs !== model_vec()) $display("FAIL pause_read: got %h expected %h", obs, model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_time_max();
    press(1'b0, 70); m_a_short();
    n_checks++;
    if (state !== 3'b010) $display("FAIL resume_run: got %b expected 010", state);
    else n_pass++;
    time_max = 1'b1;
    #1;
    n_checks++;
    if ({cnt_en, state} !== {1'b0, 3'b010})
      $display("FAIL tmax_same_cycle: got %b/%b expected 0/010", cnt_en, state);
    else n_pass++;
    cyc(1);
    time_max = 1'b0;
    m_tmax();
    n_checks++;
    if (state !== 3'b001) $display("FAIL tmax_pause: got %b expected 001", state);
    else n_pass++;
    press(1'b0, 70); m_a_short();
    n_checks++;
    if (obs !== model_vec()) $display("FAIL tmax_resume: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_long();
    press(1'b0, 70); m_a_short();
    buttonA = 1'b0;
    cyc(150);
    n_checks++;
    if (state !== 3'b001) $display("FAIL long_early: got %b expected 001", state);
    else n_pass++;
    cyc(80);
    n_checks++;
    if (state !== 3'b100) $display("FAIL long_fire: got %b expected 100", state);
    else n_pass++;
    buttonA = 1'b1; cyc(1); buttonA = 1'b0; cyc(1); buttonA = 1'b1; cyc(SETTLE);
    m_a_long();
    n_checks++;
    if (obs !== model_vec()) $display("FAIL long_release: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_glitch();
    press(1'b0, 70); m_a_short();
    time_bcd = 16'h4321;
    press(1'b1, 90); m_b_short();
    time_bcd = 16'h5555;
    press(1'b1, 15);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL glitch_b: got %h expected %h", obs, model_vec());
    else n_pass++;
    press(1'b0, 15);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL glitch_a: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    time_bcd = 16'h0777;
    buttonA = 1'b0; buttonB = 1'b0; cyc(80);
    buttonA = 1'b1; buttonB = 1'b1; cyc(SETTLE);
    m_a_short();
    n_checks++;
    if (obs !== model_vec()) $display("FAIL a_b_same_cycle: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_reset_midpress();
    buttonA = 1'b0; cyc(10);
    rst = 1'b0; cyc(2);
    rst = 1'b1; cyc(80);
    buttonA = 1'b1; cyc(SETTLE);
    m_reset();
    n_checks++;
    if (obs !== model_vec()) $display("FAIL reset_midpress: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 9);
      time_bcd = rand_bcd();
      case (op)
        0, 1:    begin press(1'b0, $urandom_range(60, 150)); m_a_short(); end
        2, 3, 4: begin press(1'b1, $urandom_range(60, 150)); m_b_short(); end
        5:       begin press(1'b1, 240); m_b_long(); end
        6:       press(1'b0, $urandom_range(5, 25));
        7:       begin time_max = 1'b1; cyc(1); time_max = 1'b0; cyc(4); m_tmax(); end
        8:       press(1'b1, $urandom_range(5, 25));
        default: begin
          if ($urandom_range(0, 3) == 0) begin press(1'b0, 240); m_a_long(); end
          else begin press(1'b1, $urandom_range(60, 150)); m_b_short(); end
        end
      endcase
      n_checks++;
      if (obs !== model_vec())
        $display("FAIL random_op%0d_%0d: got %h expected %h", i, op, obs, model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_lap_write();
    test_wrap();
    test_pause_read();
    test_time_max();
    test_long();
    test_glitch();
    test_back_to_back();
    test_reset_midpress();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control and sequencing block for the centisecond stopwatch datapath.
- Debounces and classifies the two push-buttons into short and long press events.
- Runs the CLEAR/RUN/PAUSE mode FSM and drives clear/enable to the BCD time counter.
- Owns the 9-entry lap register file, its write/read pointers and the one-hot state and pointer indicators; the seven-segment decode consumes lap_rdata and the time counter output.

Parameters:
- DEB_CYC, 500000, clock cycles between debounce samples of each button (10 ms at 50 MHz).
- SHORT_CYC, 1000000, minimum held cycles for a valid short press.
- LONG_CYC, 50000000, held cycles at which a long press fires (1 s).
- LAPS, 9, lap entries; pointers are 4 bits wide, so LAPS ≤ 16.

Ports:
- clock  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- buttonA  in  1  raw button A; 0 = pressed.
- buttonB  in  1  raw button B; 0 = pressed.
- time_bcd  in  16  current time {s_tens, s_units, cs_tens, cs_units}, BCD.
- time_max  in  1  counter has reached 60.00 s.
- cnt_clr  out  1  synchronous clear request to the time counter.
- cnt_en  out  1  counting enable to the time counter.
- lap_rdata  out  16  selected lap entry, BCD.
- lap_valid  out  1  lap_rdata holds a stored lap.
- state  out  3  one-hot mode: 100 CLEAR, 010 RUN, 001 PAUSE.
- wrnum  out  9  one-hot write pointer; MSB = entry 0.
- rdnum  out  9  one-hot read pointer; MSB = entry 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to CLEAR.
  - All counters, pointers, lap_count and lap entries go to 0.
  - Debounced button levels go to 1 (released).
  - Outputs: cnt_clr=1, cnt_en=0, lap_valid=0, lap_rdata=0, state=100, wrnum=rdnum=100000000.
- Debounce, per button:
  - A free-running counter samples the raw input every DEB_CYC cycles into the debounced level.
- Press timing, per button:
  - hold counter (32b) increments while the debounced level is 0 and saturates at LONG_CYC.
  - hold counter clears while the level is 1.
- Long event:
  - One-cycle pulse on the cycle the hold counter first equals LONG_CYC.
  - Fires while the button is still held.
  - The release that follows produces no event.
- Short event:
  - One-cycle pulse on the 0→1 edge of the debounced level, when SHORT_CYC ≤ hold < LONG_CYC.
  - A release with hold < SHORT_CYC is discarded as a glitch.
- Event priority within one cycle: A long > A short > B events.
  - Any B event coinciding with an A event is dropped.
- FSM transitions:
  - CLEAR: cnt_clr=1, cnt_en=0; lap_count, wptr and rptr held at 0. A short → RUN.
  - RUN: cnt_clr=0, cnt_en=1.
    - A short → PAUSE.
    - time_max=1 → PAUSE, with cnt_en low in that same cycle (combinational on time_max).
    - B short → lap write.
  - PAUSE: cnt_en=0.
    - A short → RUN (resume, no clear).
    - B short → read advance.
    - B long → lap_count=0, wptr=0, rptr=0; entries are not erased.
  - Any state: A long → CLEAR on the next cycle.
- Lap write (RUN + B short):
  - entry[wptr] ← time_bcd in the same cycle.
  - wptr ← wptr+1, wrapping LAPS-1→0; the oldest entry is overwritten.
  - lap_count ← min(lap_count+1, LAPS).
- Read advance (PAUSE + B short):
  - With lap_count=0: no effect.
  - Otherwise rptr ← rptr+1, wrapping lap_count-1→0.
- Entry into PAUSE: rptr ← 0.
- Read selection:
  - RUN: the most recent entry, (wptr-1) mod LAPS.
  - PAUSE: entry rptr.
  - CLEAR: none.
- lap_rdata/lap_valid: registered, one cycle after a selection change.
  - lap_valid = (lap_count≠0) and not CLEAR.
  - lap_rdata = 0 when lap_valid=0.
- Indicators:
  - state decoded from the registered FSM state.
  - wrnum/rdnum decode wptr/rptr as 9-bit one-hot; indices ≥ 9 decode to all-zero.
- Reset mid-press: the hold counter clears; the release after reset deasserts produces no event.

Test Plan:
- Reset, then hold buttonA low for 1.2 SHORT_CYC and release → state 100→010, cnt_en=1, cnt_clr=0; no event during the first DEB_CYC of bounce.
- RUN with time_bcd=0x1234, B short → entry0=0x1234, wrnum=010000000, lap_rdata=0x1234 with lap_valid=1 one cycle later.
- 10 B shorts in RUN with distinct time_bcd values → wptr wraps to 1, entry0 holds the 10th value, lap_count=9.
- A short into PAUSE with 3 laps stored, then 4 B shorts → rptr sequence 0,1,2,0,1; rdnum tracks; cnt_en=0.
- RUN, assert time_max → cnt_en=0 in the same cycle, state=001 next cycle; a following A short resumes to 010.
- Hold A for LONG_CYC in PAUSE → state=100 at the threshold with no event on release; B glitch shorter than SHORT_CYC → ignored; A and B shorts in the same cycle → only the A transition occurs.
